// File: rtl/tile_reader5x5.sv
// Reads one 5x5 tile back from the 160x120 pixel store and packs it into a 25-bit
// occupancy mask (bit 24 = top-left), flagging any pixel that matches a probe colour.
module tile_reader5x5 #(
  parameter int          RD_LAT    = 1,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter logic [7:0]  MAX_TX    = 8'd31,
  parameter logic [6:0]  MAX_TY    = 7'd23
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [2:0]  probe_colour,
  output logic        rd_en,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  input  logic [2:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic [24:0] shape,
  output logic        hit,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  ty_q, ty_d;
  logic [2:0]  probe_q, probe_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [1:0]  drain_q, drain_d;
  logic [7:0]  rd_x_q, rd_x_d;
  logic [6:0]  rd_y_q, rd_y_d;
  logic [24:0] shape_q, shape_d;
  logic        hit_q, hit_d;
  logic        err_q, err_d;

  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [4:0]  idx_cur;
  logic        cap_vld;
  logic [4:0]  cap_idx;

  assign base_x  = (tx_q << 2) + tx_q;
  assign base_y  = (ty_q << 2) + ty_q;
  assign idx_cur = ({2'b00, row_q} << 2) + {2'b00, row_q} + {2'b00, col_q};

  assign rd_en = (state_q == READ);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign rd_x  = rd_x_q;
  assign rd_y  = rd_y_q;
  assign shape = shape_q;
  assign hit   = hit_q;
  assign err   = err_q;

  // Each stage carries (issued, pixel index) so returning data knows its mask bit.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      logic       v_q, v_d;
      logic [4:0] i_q, i_d;
      if (gi == 0) begin : g_head
        always_comb begin
          v_d = rd_en;
          i_d = idx_cur;
        end
      end else begin : g_tail
        always_comb begin
          v_d = g_pipe[gi-1].v_q;
          i_d = g_pipe[gi-1].i_q;
        end
      end
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v_q <= 1'b0;
          i_q <= 5'd0;
        end else begin
          v_q <= v_d;
          i_q <= i_d;
        end
      end
    end
  endgenerate

  assign cap_vld = g_pipe[RD_LAT-1].v_q;
  assign cap_idx = g_pipe[RD_LAT-1].i_q;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    probe_d = probe_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    shape_d = shape_q;
    hit_d   = hit_q;
    err_d   = err_q;

    if (cap_vld) begin
      shape_d[5'd24 - cap_idx] = (rd_data != BG_COLOUR);
      if (rd_data == probe_q) hit_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = x_in;
          ty_d    = y_in;
          probe_d = probe_colour;
          shape_d = '0;
          hit_d   = 1'b0;
          if (x_in > MAX_TX || y_in > MAX_TY) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            row_d   = 3'd0;
            col_d   = 3'd0;
            rd_x_d  = (x_in << 2) + x_in;
            rd_y_d  = (y_in << 2) + y_in;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (col_q == 3'd4) begin
          if (row_q == 3'd4) begin
            // Last address stays on the bus through DRAIN.
            drain_d = 2'd0;
            state_d = DRAIN;
          end else begin
            col_d  = 3'd0;
            row_d  = row_q + 3'd1;
            rd_x_d = base_x;
            rd_y_d = rd_y_q + 7'd1;
          end
        end else begin
          col_d  = col_q + 3'd1;
          rd_x_d = rd_x_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) state_d = DONE;
        else                           drain_d = drain_q + 2'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= 8'd0;
      ty_q    <= 7'd0;
      probe_q <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      drain_q <= 2'd0;
      rd_x_q  <= 8'd0;
      rd_y_q  <= 7'd0;
      shape_q <= 25'd0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      probe_q <= probe_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      shape_q <= shape_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tile_reader5x5.sv
// Directed bench for tile_reader5x5: one RD_LAT=1 instance and one RD_LAT=3 instance
// sharing a behavioural pixel store.
module tb_tile_reader5x5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  probe;

  logic        rd_en_a, busy_a, done_a, hit_a, err_a;
  logic [7:0]  rd_x_a;
  logic [6:0]  rd_y_a;
  logic [2:0]  rd_data_a;
  logic [24:0] shape_a;

  logic        rd_en_b, busy_b, done_b, hit_b, err_b;
  logic [7:0]  rd_x_b;
  logic [6:0]  rd_y_b;
  logic [2:0]  pb0, pb1, pb2;
  logic [24:0] shape_b;

  logic [2:0]  mem [0:119][0:159];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  tile_reader5x5 u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .x_in(x_in), .y_in(y_in), .probe_colour(probe),
    .rd_en(rd_en_a), .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .shape(shape_a), .hit(hit_a), .err(err_a)
  );

  tile_reader5x5 #(.RD_LAT(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .x_in(x_in), .y_in(y_in), .probe_colour(probe),
    .rd_en(rd_en_b), .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_data(pb2),
    .busy(busy_b), .done(done_b), .shape(shape_b), .hit(hit_b), .err(err_b)
  );

  // Store returns junk colour 3'b010 for cycles without a read strobe.
  always @(posedge clock) begin
    rd_data_a <= rd_en_a ? mem[rd_y_a][rd_x_a] : 3'b010;
    pb0       <= rd_en_b ? mem[rd_y_b][rd_x_b] : 3'b010;
    pb1       <= pb0;
    pb2       <= pb1;
  end

  // Read-address monitor for the selected instance.
  bit         sel_b = 1'b0;
  int         rd_cnt = 0;
  int         ord_err = 0;
  logic [7:0] exp_bx, first_x, last_x;
  logic [6:0] exp_by, first_y, last_y;

  always @(negedge clock) begin
    if (sel_b ? rd_en_b : rd_en_a) begin
      if (rd_cnt == 0) begin
        first_x = sel_b ? rd_x_b : rd_x_a;
        first_y = sel_b ? rd_y_b : rd_y_a;
      end
      last_x = sel_b ? rd_x_b : rd_x_a;
      last_y = sel_b ? rd_y_b : rd_y_a;
      if (last_x != exp_bx + 8'(rd_cnt % 5) || last_y != exp_by + 7'(rd_cnt / 5))
        ord_err++;
      rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill_tile(input int tx, input int ty, input logic [24:0] pat,
                           input logic [2:0] colour);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mem[5*ty + r][5*tx + c] = pat[24 - (5*r + c)] ? colour : 3'b000;
  endtask

  task automatic arm(input bit use_b, input logic [7:0] x, input logic [6:0] y,
                     input logic [2:0] pr);
    @(negedge clock);
    sel_b   = use_b;
    rd_cnt  = 0;
    ord_err = 0;
    exp_bx  = 8'(5 * int'(x));
    exp_by  = 7'(5 * int'(y));
    x_in    = x;
    y_in    = y;
    probe   = pr;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_tile(input bit use_b, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] pr, output int dcyc);
    arm(use_b, x, y, pr);
    dcyc = -1;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      @(negedge clock);
      if (use_b ? done_b : done_a) dcyc = c;
    end
    $display("tile (%0d,%0d) probe %03b: done cycle %0d, reads %0d, shape %07h hit %0b err %0b",
             x, y, pr, dcyc, rd_cnt, use_b ? shape_b : shape_a,
             use_b ? hit_b : hit_a, use_b ? err_b : err_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [24:0] PAT2 = 25'b0111011111110001111101110;
  localparam logic [24:0] PAT6 = 25'h1B2D0E7;

  initial begin
    int dc;
    int ndone;
    int first_done;

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    x_in    = 8'd0;
    y_in    = 7'd0;
    probe   = 3'd0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        mem[yy][xx] = 3'b000;

    repeat (3) @(negedge clock);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_rd_en", 32'(rd_en_a), 32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    check("rst_shape", 32'(shape_a), 32'd0);
    check("rst_hit_err", {30'd0, hit_a, err_a}, 32'd0);
    check("rst_addr",  {17'd0, rd_x_a, rd_y_a}, 32'd0);
    reset_n = 1'b1;

    // All-background tile at the origin.
    run_tile(1'b0, 8'd0, 7'd0, 3'b101, dc);
    check("t1_done_cyc", 32'(dc), 32'd27);
    check("t1_shape", 32'(shape_a), 32'd0);
    check("t1_hit_err", {30'd0, hit_a, err_a}, 32'd0);
    check("t1_reads", 32'(rd_cnt), 32'd25);
    check("t1_order", 32'(ord_err), 32'd0);
    check("t1_first", {17'd0, first_x, first_y}, 32'd0);
    check("t1_last",  {17'd0, last_x, last_y}, {17'd0, 8'd4, 7'd4});

    // Patterned tile, matching probe.
    fill_tile(3, 2, PAT2, 3'b110);
    run_tile(1'b0, 8'd3, 7'd2, 3'b110, dc);
    check("t2_done_cyc", 32'(dc), 32'd27);
    check("t2_shape", 32'(shape_a), 32'h0EFE3EE);
    check("t2_hit_err", {30'd0, hit_a, err_a}, 32'd2);
    check("t2_order", 32'(ord_err), 32'd0);
    check("t2_first", {17'd0, first_x, first_y}, {17'd0, 8'd15, 7'd10});
    check("t2_last",  {17'd0, last_x, last_y}, {17'd0, 8'd19, 7'd14});

    // Same tile, probe colour absent.
    run_tile(1'b0, 8'd3, 7'd2, 3'b011, dc);
    check("t2b_shape", 32'(shape_a), 32'h0EFE3EE);
    check("t2b_hit", 32'(hit_a), 32'd0);

    // Bottom-right legal tile, fully occupied.
    fill_tile(31, 23, 25'h1FFFFFF, 3'b001);
    run_tile(1'b0, 8'd31, 7'd23, 3'b100, dc);
    check("t3_done_cyc", 32'(dc), 32'd27);
    check("t3_shape", 32'(shape_a), 32'h1FFFFFF);
    check("t3_hit_err", {30'd0, hit_a, err_a}, 32'd0);
    check("t3_order", 32'(ord_err), 32'd0);
    check("t3_last", {17'd0, last_x, last_y}, {17'd0, 8'd159, 7'd119});

    // Out-of-range column, then row.
    run_tile(1'b0, 8'd32, 7'd0, 3'b001, dc);
    check("t4x_done_cyc", 32'(dc), 32'd1);
    check("t4x_err", 32'(err_a), 32'd1);
    check("t4x_shape", 32'(shape_a), 32'd0);
    check("t4x_hit", 32'(hit_a), 32'd0);
    check("t4x_reads", 32'(rd_cnt), 32'd0);
    run_tile(1'b0, 8'd0, 7'd24, 3'b000, dc);
    check("t4y_done_cyc", 32'(dc), 32'd1);
    check("t4y_err", 32'(err_a), 32'd1);
    check("t4y_reads", 32'(rd_cnt), 32'd0);

    // Reset in the middle of READ.
    arm(1'b0, 8'd3, 7'd2, 3'b110);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_rd_en", 32'(rd_en_a), 32'd0);
    check("t5_done", 32'(done_a), 32'd0);
    check("t5_shape", 32'(shape_a), 32'd0);
    check("t5_hit_err", {30'd0, hit_a, err_a}, 32'd0);
    check("t5_addr", {17'd0, rd_x_a, rd_y_a}, 32'd0);
    $display("reset asserted in READ cycle 10: busy %0b shape %07h", busy_a, shape_a);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_tile(1'b0, 8'd3, 7'd2, 3'b110, dc);
    check("t5r_done_cyc", 32'(dc), 32'd27);
    check("t5r_shape", 32'(shape_a), 32'h0EFE3EE);
    check("t5r_hit", 32'(hit_a), 32'd1);
    check("t5r_reads", 32'(rd_cnt), 32'd25);

    // RD_LAT=3 instance; stray starts during READ and DONE.
    fill_tile(1, 1, PAT6, 3'b011);
    arm(1'b1, 8'd1, 7'd1, 3'b011);
    ndone = 0;
    first_done = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      start_b = 1'b0;
      if (c == 5) start_b = 1'b1;
      if (done_b) begin
        ndone++;
        if (first_done < 0) first_done = c;
        start_b = 1'b1;
      end
    end
    start_b = 1'b0;
    $display("lat3 tile (1,1): done count %0d first at %0d, reads %0d, shape %07h hit %0b",
             ndone, first_done, rd_cnt, shape_b, hit_b);
    check("t6_ndone", 32'(ndone), 32'd1);
    check("t6_done_cyc", 32'(first_done), 32'd29);
    check("t6_shape", 32'(shape_b), 32'(PAT6));
    check("t6_hit_err", {30'd0, hit_b, err_b}, 32'd2);
    check("t6_reads", 32'(rd_cnt), 32'd25);
    check("t6_order", 32'(ord_err), 32'd0);
    check("t6_busy", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
